// File: rtl/async_receiver_pkg.sv
// Shared constants and FSM encoding for the inter-board serial link.
// The transmitter side imports the same frame constants.
package async_receiver_pkg;

    localparam int FRAME_BITS = 72;
    localparam int CMD_BITS   = 8;
    localparam int DATA_BITS  = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        TRAILER  = 3'd3,
        WAIT_LOW = 3'd4
    } rx_state_t;

endpackage

// File: rtl/async_receiver_if.sv
// Received-frame bus: command/data plus the one-cycle valid and frame_error strobes.
// The receiver drives it (master); the command decoder listens (slave).
interface async_receiver_if;
    import async_receiver_pkg::*;

    logic [CMD_BITS-1:0]  command;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_error;

    modport master (output command, output data, output valid, output frame_error);
    modport slave  (input  command, input  data, input  valid, input  frame_error);

endinterface

// File: rtl/async_receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/async_receiver.sv
// Oversampling receiver for the idle-low serial link: start bit 1,
// 72 payload bits MSB first, trailer bit 1. Presents command/data with a
// one-cycle valid strobe, or a one-cycle frame_error on a bad trailer.
module async_receiver #(
    parameter int CLOCKS_PER_BIT = 10,
    parameter int FRAME_BITS     = 72
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RxD,
    async_receiver_if.master       rx,
    output logic                   busy,
    output logic [3:0]             debug
);
    import async_receiver_pkg::*;

    // The countdown expires on the cycle it holds 1, so a reload of N puts
    // the next sample exactly N cycles later.
    localparam logic [7:0] HALF_BIT = 8'(CLOCKS_PER_BIT / 2);
    localparam logic [7:0] FULL_BIT = 8'(CLOCKS_PER_BIT);

    logic                   rx_sync;
    logic                   rx_prev;
    rx_state_t              state;
    logic [7:0]             bit_cnt;
    logic [6:0]             bits_left;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic [CMD_BITS-1:0]    command_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   frame_error_q;
    logic                   tick;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (RxD),
        .q     (rx_sync)
    );

    // Guarded with <= so a stray zero can never wrap the counter.
    assign tick = (bit_cnt <= 8'd1);

    // Frame recovery FSM; strobes default low and are raised for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rx_prev       <= 1'b0;
            bit_cnt       <= '0;
            bits_left     <= '0;
            shift_reg     <= '0;
            command_q     <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_prev       <= rx_sync;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a genuine 0->1 edge starts a frame.
                    if (rx_sync && !rx_prev) begin
                        bit_cnt <= HALF_BIT;
                        state   <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_sync) begin
                            bit_cnt   <= FULL_BIT;
                            shift_reg <= '0;
                            bits_left <= 7'(FRAME_BITS);
                            state     <= DATA;
                        end else begin
                            // Glitch: line fell before mid start bit.
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 8'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], rx_sync};
                        bits_left <= bits_left - 7'd1;
                        bit_cnt   <= FULL_BIT;
                        if (bits_left == 7'd1) state <= TRAILER;
                    end else begin
                        bit_cnt <= bit_cnt - 8'd1;
                    end
                end
                TRAILER: begin
                    if (tick) begin
                        if (rx_sync) begin
                            command_q <= shift_reg[FRAME_BITS-1 -: CMD_BITS];
                            data_q    <= shift_reg[DATA_BITS-1:0];
                            valid_q   <= 1'b1;
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                        bit_cnt <= '0;
                        state   <= WAIT_LOW;
                    end else begin
                        bit_cnt <= bit_cnt - 8'd1;
                    end
                end
                WAIT_LOW: begin
                    // A stuck-high or stretched trailer must drop before re-arming.
                    if (!rx_sync) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx.command     = command_q;
    assign rx.data        = data_q;
    assign rx.valid       = valid_q;
    assign rx.frame_error = frame_error_q;
    assign busy           = (state != IDLE);
    assign debug          = {rx_sync, state[2:0]};

endmodule

// File: tb/tb_async_receiver.sv
// Directed bench for async_receiver at 10 clocks per bit.
module tb_async_receiver;
    import async_receiver_pkg::*;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD;
    logic       busy;
    logic [3:0] debug;

    async_receiver_if rx_if ();

    async_receiver #(.CLOCKS_PER_BIT(CPB), .FRAME_BITS(72)) dut (
        .clk   (clk),
        .reset (reset),
        .RxD   (RxD),
        .rx    (rx_if),
        .busy  (busy),
        .debug (debug)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_valid = 0;
    int n_fe    = 0;
    int n_both  = 0;
    int          vcyc[$];
    logic [7:0]  vcmd[$];
    logic [63:0] vdat[$];

    // Strobe monitor: counts pulses and records what each valid carried.
    always @(negedge clk) begin
        cyc++;
        if (rx_if.valid) begin
            n_valid++;
            vcyc.push_back(cyc);
            vcmd.push_back(rx_if.command);
            vdat.push_back(rx_if.data);
        end
        if (rx_if.frame_error) n_fe++;
        if (rx_if.valid && rx_if.frame_error) n_both++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic b, input int n);
        RxD = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [63:0] d,
                              input logic trl, input int trl_cycles, input int guard);
        logic [71:0] bits;
        bits = {c, d};
        drive(1'b1, CPB);
        for (int i = 71; i >= 0; i--) drive(bits[i], CPB);
        drive(trl, trl_cycles);
        drive(1'b0, guard);
    endtask

    int v0, f0, q0, bcnt;

    initial begin
        RxD   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_command", 64'(rx_if.command), 64'h0);
        chk("rst_data",    rx_if.data, 64'h0);
        chk("rst_valid",   64'(rx_if.valid), 64'h0);
        chk("rst_ferr",    64'(rx_if.frame_error), 64'h0);
        chk("rst_busy",    64'(busy), 64'h0);
        chk("rst_debug",   64'(debug), 64'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single clean frame.
        v0 = n_valid; f0 = n_fe;
        send_frame(8'hA5, 64'h0123456789ABCDEF, 1'b1, CPB, 20);
        chk("f1_valid_cnt", 64'(n_valid - v0), 64'd1);
        chk("f1_ferr_cnt",  64'(n_fe - f0), 64'd0);
        chk("f1_command",   64'(rx_if.command), 64'hA5);
        chk("f1_data",      rx_if.data, 64'h0123456789ABCDEF);
        chk("f1_busy_idle", 64'(busy), 64'h0);

        // 3-cycle glitch on an idle line.
        v0 = n_valid; f0 = n_fe; bcnt = 0;
        RxD = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 3) RxD = 1'b0;
            @(negedge clk);
            if (busy) bcnt++;
        end
        chk("gl_busy_seen",  64'(bcnt >= 1), 64'd1);
        chk("gl_busy_short", 64'(bcnt <= 6), 64'd1);
        chk("gl_valid_cnt",  64'(n_valid - v0), 64'd0);
        chk("gl_ferr_cnt",   64'(n_fe - f0), 64'd0);
        chk("gl_busy_idle",  64'(busy), 64'h0);

        // Bad trailer: frame dropped, previous values kept.
        v0 = n_valid; f0 = n_fe;
        send_frame(8'h3C, 64'hFFFF0000FFFF0000, 1'b0, CPB, 20);
        chk("fe_ferr_cnt",  64'(n_fe - f0), 64'd1);
        chk("fe_valid_cnt", 64'(n_valid - v0), 64'd0);
        chk("fe_command",   64'(rx_if.command), 64'hA5);
        chk("fe_data",      rx_if.data, 64'h0123456789ABCDEF);

        // Reset during data bit 30 aborts the frame.
        v0 = n_valid; f0 = n_fe;
        begin
            logic [71:0] bits;
            bits = {8'hC3, 64'hDEADBEEFCAFEF00D};
            drive(1'b1, CPB);
            for (int i = 71; i > 41; i--) drive(bits[i], CPB);
            drive(bits[41], 5);
        end
        reset = 1'b1;
        RxD   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rs_busy",    64'(busy), 64'h0);
        chk("rs_command", 64'(rx_if.command), 64'h0);
        chk("rs_data",    rx_if.data, 64'h0);
        chk("rs_valid",   64'(rx_if.valid), 64'h0);
        repeat (30) @(negedge clk);
        chk("rs_no_strobe", 64'((n_valid - v0) + (n_fe - f0)), 64'd0);
        v0 = n_valid;
        send_frame(8'h01, 64'h1, 1'b1, CPB, 20);
        chk("rs_valid_cnt", 64'(n_valid - v0), 64'd1);
        chk("rs_command2",  64'(rx_if.command), 64'h01);
        chk("rs_data2",     rx_if.data, 64'h1);

        // Back-to-back frames with a 20-cycle guard.
        q0 = vcyc.size();
        send_frame(8'h11, 64'hAAAAAAAAAAAAAAAA, 1'b1, CPB, 20);
        send_frame(8'h22, 64'h5555555555555555, 1'b1, CPB, 20);
        chk("bb_valid_cnt", 64'(vcyc.size() - q0), 64'd2);
        if (vcyc.size() - q0 == 2) begin
            chk("bb_spacing", 64'(vcyc[q0+1] - vcyc[q0]), 64'd760);
            chk("bb_cmd0",  64'(vcmd[q0]), 64'h11);
            chk("bb_dat0",  vdat[q0], 64'hAAAAAAAAAAAAAAAA);
            chk("bb_cmd1",  64'(vcmd[q0+1]), 64'h22);
            chk("bb_dat1",  vdat[q0+1], 64'h5555555555555555);
        end

        // Trailer held high for 50 cycles.
        v0 = n_valid; f0 = n_fe;
        send_frame(8'h77, 64'h0F0F0F0F0F0F0F0F, 1'b1, 50, 20);
        chk("hh_valid_cnt", 64'(n_valid - v0), 64'd1);
        repeat (200) @(negedge clk);
        chk("hh_valid_cnt2", 64'(n_valid - v0), 64'd1);
        chk("hh_ferr_cnt",   64'(n_fe - f0), 64'd0);
        chk("hh_command",    64'(rx_if.command), 64'h77);
        chk("hh_data",       rx_if.data, 64'h0F0F0F0F0F0F0F0F);
        chk("hh_busy_idle",  64'(busy), 64'h0);

        chk("never_both", 64'(n_both), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/async_receiver.md
Name: async_receiver

Overview:
- Receiving end of the single-line asynchronous link used between boards.
- Frame format on the line:
  - Idle level is 0.
  - Start bit is 1.
  - 72 data bits follow, MSB first: bits 71:64 are the command, bits 63:0 are the data.
  - A trailer bit of 1 follows the data.
  - The line then returns low for a guard interval of at least 2 bit times.
- The block oversamples the line, recovers each frame and presents command/data with a one-cycle valid strobe.
- It feeds the command decoder in the receiving FPGA.

Parameters:
- CLOCKS_PER_BIT, 10, clk cycles per bit on the line; legal range 4..255.
- FRAME_BITS, 72, payload bits per frame; fixed at 72 because the output split (8 command + 64 data) depends on it.

Ports:
- clk  input  1  system clock, the same frequency as the transmitter's clock.
- reset  input  1  synchronous, active-high reset.
- RxD  input  1  asynchronous serial line.
- command  output  8  received command, frame bits 71:64.
- data  output  64  received data, frame bits 63:0.
- valid  output  1  one-cycle strobe: command/data were updated with a good frame.
- frame_error  output  1  one-cycle strobe: trailer bit sampled 0, frame discarded.
- busy  output  1  high whenever the FSM is not in IDLE.
- debug  output  4  {rx_sync, state[2:0]}.

Behaviour:
- Reset values: command=0, data=0, valid=0, frame_error=0, busy=0, state=IDLE, all counters 0.
- Reset mid-frame aborts the frame. No valid or frame_error is produced for it.
- RxD passes through a 2-FF synchronizer to give rx_sync. Only rx_sync and its one-cycle delayed copy rx_prev are used.
- IDLE:
  - A rising edge (rx_sync=1 and rx_prev=0) loads the bit counter with CLOCKS_PER_BIT/2 (integer division).
  - The FSM then moves to START.
  - A line that is already high when IDLE is entered is not treated as a start.
- START:
  - Counts down. At zero, rx_sync is sampled.
  - If the sample is 1: load CLOCKS_PER_BIT, clear the shift register, set bits_left=FRAME_BITS, go to DATA.
  - If the sample is 0: false start (glitch), return to IDLE silently.
- DATA:
  - Each time the countdown reaches zero: shift_reg <= {shift_reg[70:0], rx_sync}, decrement bits_left, reload CLOCKS_PER_BIT.
  - Once 72 bits have been sampled, go to TRAILER. The bit counter is reloaded so the next sample lands CLOCKS_PER_BIT later.
- TRAILER:
  - At countdown zero, rx_sync is sampled.
  - If 1: command <= shift_reg[71:64], data <= shift_reg[63:0], and valid=1 on the following cycle.
  - If 0: frame_error=1 on the following cycle; command/data keep their previous values.
  - Either way, go to WAIT_LOW.
- WAIT_LOW:
  - Stays here until rx_sync=0, then goes to IDLE.
  - This prevents a stuck-high line or an extended trailer from being decoded as a new start.
- Sample timing: the sample points sit CLOCKS_PER_BIT/2, then +k*CLOCKS_PER_BIT cycles after the edge-detect cycle, i.e. bit centres.
- valid and frame_error are never high in the same cycle. Each is high for exactly one cycle per frame.
- Outputs hold their values between frames. There is no backpressure; the consumer must capture on valid. The minimum spacing between valid pulses is (FRAME_BITS+4)*CLOCKS_PER_BIT cycles.
- Minimum frame-to-frame gap accepted: trailer followed by at least 1 bit time low. The transmitter guarantees 2.
- Counter widths:
  - Bit counter is 8 bits.
  - bits_left is 7 bits.
  - Counters never wrap; reload happens on the zero cycle.

Decomposition:
- Shared package: FSM state encoding (IDLE, START, DATA, TRAILER, WAIT_LOW) and the constants FRAME_BITS=72, CMD_BITS=8, DATA_BITS=64. The transmitter side uses the same constants.
- One natural sub-module, sync_2ff: a two-flop synchronizer with reset value 0, reusable for other asynchronous inputs.

Test Plan:
- Single frame, command=8'hA5, data=64'h0123456789ABCDEF, 10 clk/bit, trailer 1, 20-cycle guard -> exactly one valid pulse; command=8'hA5, data=64'h0123456789ABCDEF; busy returns to 0 once the line is low.
- 3-cycle high glitch on idle RxD -> START rejects it; no valid, no frame_error; busy high for at most 6 cycles and then back to 0.
- Frame command=8'h3C, data=64'hFFFF0000FFFF0000 with trailer forced 0 -> frame_error pulses once, valid stays 0, outputs keep the previous frame's values.
- reset asserted for 1 cycle during data bit 30 of a frame -> next cycle busy=0, outputs=0, no strobe; the following clean frame (8'h01, 64'h1) is received correctly.
- Two back-to-back frames (8'h11/64'hAAAA…A, then 8'h22/64'h5555…5) with a 20-cycle guard -> two valid pulses 760 cycles apart carrying the correct values.
- Trailer held high for 50 cycles after the frame -> one valid only; no second frame until the line drops and a fresh rising edge occurs.
